// File: rtl/act_cfg_loader.sv
// Bit-serial configuration loader for the ACT cell: shifts a frame into a shadow and commits all four words at once.
// Optional even-parity frame check is compiled in with ACT_CFG_PARITY_EN.
module act_cfg_loader #(
  parameter int bits = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_valid,
  input  logic            cfg_bit,
  output logic            cfg_ready,
  input  logic            cfg_abort,
  output logic [bits-1:0] D00,
  output logic [bits-1:0] D01,
  output logic [bits-1:0] D10,
  output logic [bits-1:0] D11,
  output logic            cfg_done,
  output logic            cfg_err,
  output logic            busy
);

  localparam int DW = 4 * bits;
`ifdef ACT_CFG_PARITY_EN
  localparam int FL = DW + 1;
`else
  localparam int FL = DW;
`endif
  localparam int CW = $clog2(FL + 1);

  typedef enum logic {LOAD, CHECK} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   shadow_q, shadow_d;
  logic [DW-1:0]   word_q, word_d;
  logic            done_q, done_d;
  logic            hs;
`ifdef ACT_CFG_PARITY_EN
  logic            par_q, par_d;
  logic            err_q, err_d;
`endif

  assign cfg_ready = (state_q == LOAD) && !rst;
  assign hs        = cfg_valid && cfg_ready;
  assign busy      = (cnt_q != '0) || (state_q == CHECK);
  assign cfg_done  = done_q;
`ifdef ACT_CFG_PARITY_EN
  assign cfg_err   = err_q;
`else
  assign cfg_err   = 1'b0;
`endif

  assign D00 = word_q[bits-1:0];
  assign D01 = word_q[2*bits-1:bits];
  assign D10 = word_q[3*bits-1:2*bits];
  assign D11 = word_q[4*bits-1:3*bits];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    word_d   = word_q;
    done_d   = 1'b0;
`ifdef ACT_CFG_PARITY_EN
    par_d    = par_q;
    err_d    = 1'b0;
`endif
    if (cfg_abort) begin
      // Abort wins everywhere, including a pending commit in CHECK.
      state_d = LOAD;
      cnt_d   = '0;
`ifdef ACT_CFG_PARITY_EN
      par_d   = 1'b0;
`endif
    end else if (state_q == LOAD) begin
      if (hs) begin
        // The parity bit lands at index DW, which has no shadow slot.
        for (int i = 0; i < DW; i++) begin
          if (cnt_q == CW'(i)) shadow_d[i] = cfg_bit;
        end
`ifdef ACT_CFG_PARITY_EN
        par_d = par_q ^ cfg_bit;
`endif
        if (cnt_q == CW'(FL - 1)) begin
          state_d = CHECK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end else begin
      state_d = LOAD;
`ifdef ACT_CFG_PARITY_EN
      par_d   = 1'b0;
      if (!par_q) begin
        word_d = shadow_q;
        done_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
`else
      word_d = shadow_q;
      done_d = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      word_q  <= '0;
      done_q  <= 1'b0;
`ifdef ACT_CFG_PARITY_EN
      par_q   <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      done_q  <= done_d;
`ifdef ACT_CFG_PARITY_EN
      par_q   <= par_d;
      err_q   <= err_d;
`endif
    end
  end

  // Shadow contents between frames are don't-care, so it carries no reset.
  always_ff @(posedge clk) begin
    shadow_q <= shadow_d;
  end

endmodule

// File: tb/tb_act_cfg_loader.sv
// Scoreboard bench for act_cfg_loader (bits=2); adapts to ACT_CFG_PARITY_EN.
`timescale 1ns/1ps
module tb_act_cfg_loader;

  logic       clk = 1'b0;
  logic       rst, cfg_valid, cfg_bit, cfg_ready, cfg_abort;
  logic       cfg_done, cfg_err, busy;
  logic [1:0] d00, d01, d10, d11;

  act_cfg_loader #(.bits(2)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_bit(cfg_bit),
    .cfg_ready(cfg_ready), .cfg_abort(cfg_abort),
    .D00(d00), .D01(d01), .D10(d10), .D11(d11),
    .cfg_done(cfg_done), .cfg_err(cfg_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    logic       ok;
    logic [7:0] data;
    int         edge_n;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] model;
  int         errors = 0;
  int         checks = 0;
  int         last_edge, first_edge;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] dout();
    return {d11, d10, d01, d00};
  endfunction

  task automatic send_bit(input logic b, input bit gap);
    bit hs = 1'b0;
    int tries = 0;
    if (gap) begin
      @(negedge clk);
      cfg_valid = 1'b0;
      cfg_bit   = 1'($urandom_range(0, 1));
    end
    while (!hs && tries < 20) begin
      @(negedge clk);
      cfg_valid = 1'b1;
      cfg_bit   = b;
      #1;
      hs = cfg_ready;
      @(posedge clk);
      #1;
      tries++;
    end
    if (!hs) check_eq("hs_timeout", 32'd0, 32'd1);
    last_edge = edge_cnt;
  endtask

  task automatic send_frame(input logic [7:0] data, input logic par, input bit gap, input bit push);
    logic ok;
    for (int i = 0; i < 8; i++) begin
      send_bit(data[i], gap);
      if (i == 0) first_edge = last_edge;
    end
`ifdef ACT_CFG_PARITY_EN
    send_bit(par, gap);
    ok = ~(^{data, par});
`else
    ok = 1'b1;
`endif
    if (push) begin
      if (ok) model = data;
      sb.push_back('{ok, model, last_edge});
    end
    $display("frame sent data=%02h par=%0d expect_ok=%0d queued=%0d", data, par, ok, push);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      cfg_valid = 1'b0;
      cfg_bit   = 1'b0;
    end
  endtask

  // Monitor: every done/err pulse must match the head of the scoreboard.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (cfg_done || cfg_err) begin
        if (sb.size() == 0) begin
          check_eq("spurious_pulse", {30'd0, cfg_done, cfg_err}, 32'd0);
        end else begin
          e = sb.pop_front();
          check_eq("done", {31'd0, cfg_done}, {31'd0, e.ok});
          check_eq("err", {31'd0, cfg_err}, {31'd0, !e.ok});
          check_eq("dout", {24'd0, dout()}, {24'd0, e.data});
          check_eq("latency", edge_cnt, e.edge_n + 1);
          $display("commit done=%0d err=%0d D=%02h edge=%0d", cfg_done, cfg_err, dout(), edge_cnt);
        end
      end else if (sb.size() > 0 && edge_cnt > sb[0].edge_n + 1) begin
        check_eq("missing_pulse", 32'd0, 32'd1);
        void'(sb.pop_front());
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int l1;
    rst = 1'b1; cfg_valid = 1'b0; cfg_bit = 1'b0; cfg_abort = 1'b0;
    model = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_dout", {24'd0, dout()}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, cfg_done}, 32'd0);
    check_eq("rst_err", {31'd0, cfg_err}, 32'd0);
    check_eq("rst_ready", {31'd0, cfg_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("ready_after_rst", {31'd0, cfg_ready}, 32'd1);

    // Good frame: D00=1 D01=2 D10=3 D11=0
    send_frame(8'h39, 1'b0, 1'b0, 1'b1);
    check_eq("ready_in_check", {31'd0, cfg_ready}, 32'd0);
    check_eq("busy_in_check", {31'd0, busy}, 32'd1);
    idle(1);
    @(posedge clk);
    #1;
    check_eq("ready_after_check", {31'd0, cfg_ready}, 32'd1);
    check_eq("busy_after_check", {31'd0, busy}, 32'd0);
    idle(3);

    // Bad parity (commits instead when parity is compiled out)
    send_frame(8'h80, 1'b0, 1'b0, 1'b1);
    idle(4);
    check_eq("hold_after_bad", {24'd0, dout()}, {24'd0, model});

    // Abort after 5 accepted bits, then all-ones frame
    for (int i = 0; i < 5; i++) send_bit(1'(i & 1), 1'b0);
    @(negedge clk);
    cfg_abort = 1'b1; cfg_valid = 1'b1; cfg_bit = 1'b1;
    @(posedge clk);
    #1;
    check_eq("abort_busy", {31'd0, busy}, 32'd0);
    check_eq("abort_dout", {24'd0, dout()}, {24'd0, model});
    @(negedge clk);
    cfg_abort = 1'b0; cfg_valid = 1'b0;
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1);
    idle(4);

    // Gapped valid with garbage on idle cycles
    send_frame(8'h39, 1'b0, 1'b1, 1'b1);
    idle(4);

    // Reset mid-frame
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1; cfg_valid = 1'b0;
    @(posedge clk);
    #1;
    check_eq("midrst_dout", {24'd0, dout()}, 32'd0);
    check_eq("midrst_busy", {31'd0, busy}, 32'd0);
    check_eq("midrst_ready", {31'd0, cfg_ready}, 32'd0);
    model = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    send_frame(8'h39, 1'b0, 1'b0, 1'b1);
    idle(4);

    // Back-to-back frames, second one with odd data and parity bit 1
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    l1 = last_edge;
    send_frame(8'h07, 1'b1, 1'b0, 1'b1);
    check_eq("b2b_first_bit", first_edge, l1 + 2);
    idle(4);

    // Abort during CHECK cancels the commit
    send_frame(8'hC3, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    cfg_abort = 1'b1; cfg_valid = 1'b0;
    @(posedge clk);
    #1;
    check_eq("chk_abort_busy", {31'd0, busy}, 32'd0);
    check_eq("chk_abort_dout", {24'd0, dout()}, {24'd0, model});
    @(negedge clk);
    cfg_abort = 1'b0;
    idle(5);

    check_eq("sb_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
